flash_pin_arbiter: RTL and testbench



---
 rtl/flash_pin_arbiter.sv | 135 +++++++++++++
 tb/tb_flash_pin_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/flash_pin_arbiter.sv
// Two-master arbiter for a shared quad-SPI flash pad set; A has fixed priority, pads park during an inter-owner gap.
// Optional build macro FLASH_ARB_TIMEOUT_EN adds preemption of A after TMO_CYC cycles of B waiting.
module flash_pin_arbiter #(
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned TMO_CYC = 1024
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       req_a,
    input  logic       csn_a,
    input  logic       sclk_a,
    input  logic       doe_a,
    input  logic [3:0] do_a,
    input  logic       req_b,
    input  logic       csn_b,
    input  logic       sclk_b,
    input  logic       doe_b,
    input  logic [3:0] do_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic [3:0] di_a,
    output logic [3:0] di_b,
    output logic       fcen,
    output logic       fsclk,
    output logic       fdoe,
    output logic [3:0] fdo,
    input  logic [3:0] fdi,
    output logic       preempt_o
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, GAP} state_t;

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYC - 1);

    state_t     state_q, state_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic       preempt;
    logic       b_first;

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LIM = 16'(TMO_CYC - 1);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        bpri_q, bpri_d;

    always_comb begin
        preempt = (state_q == OWN_A) && (tmo_cnt_q >= TMO_LIM) && csn_a;
        b_first = bpri_q && req_b;
        tmo_cnt_d = 16'd0;
        if (state_q == OWN_A && req_b)
            tmo_cnt_d = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
        bpri_d = bpri_q;
        if (preempt)
            bpri_d = 1'b1;
        else if (state_q == IDLE && state_d == OWN_B)
            bpri_d = 1'b0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tmo_cnt_q <= 16'd0;
            bpri_q    <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            bpri_q    <= bpri_d;
        end
    end
`else
    assign preempt = 1'b0;
    assign b_first = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (b_first)    state_d = OWN_B;
                else if (req_a) state_d = OWN_A;
                else if (req_b) state_d = OWN_B;
            end
            OWN_A: begin
                // Release waits for chip-select high so a transaction is never cut.
                if (preempt || (!req_a && csn_a)) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                end
            end
            OWN_B: begin
                if (!req_b && csn_b) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                end
            end
            default: begin
                if (gap_cnt_q == 8'd0) state_d = IDLE;
                else                   gap_cnt_d = gap_cnt_q - 8'd1;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            gap_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    always_comb begin
        gnt_a     = (state_q == OWN_A);
        gnt_b     = (state_q == OWN_B);
        preempt_o = preempt;
        fcen      = 1'b1;
        fsclk     = 1'b0;
        fdoe      = 1'b0;
        fdo       = 4'd0;
        if (gnt_a) begin
            fcen  = csn_a;
            fsclk = sclk_a;
            fdoe  = doe_a;
            fdo   = do_a;
        end else if (gnt_b) begin
            fcen  = csn_b;
            fsclk = sclk_b;
            fdoe  = doe_b;
            fdo   = do_b;
        end
        di_a = gnt_a ? fdi : 4'd0;
        di_b = gnt_b ? fdi : 4'd0;
    end

endmodule

// File: tb/tb_flash_pin_arbiter.sv
// Bench for flash_pin_arbiter: directed scenarios plus random traffic, checked per cycle against an ownership model.
module tb_flash_pin_arbiter;

    localparam int GAP = 4;
    localparam int TMO = 16;
`ifdef FLASH_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i;
    logic       req_a, csn_a, sclk_a, doe_a;
    logic [3:0] do_a;
    logic       req_b, csn_b, sclk_b, doe_b;
    logic [3:0] do_b;
    logic       gnt_a, gnt_b;
    logic [3:0] di_a, di_b;
    logic       fcen, fsclk, fdoe;
    logic [3:0] fdo;
    logic [3:0] fdi;
    logic       preempt_o;

    flash_pin_arbiter #(.GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .req_a(req_a), .csn_a(csn_a), .sclk_a(sclk_a), .doe_a(doe_a), .do_a(do_a),
        .req_b(req_b), .csn_b(csn_b), .sclk_b(sclk_b), .doe_b(doe_b), .do_b(do_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .di_a(di_a), .di_b(di_b),
        .fcen(fcen), .fsclk(fsclk), .fdoe(fdoe), .fdo(fdo), .fdi(fdi),
        .preempt_o(preempt_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [17:0] v;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Model: who owns the pins (0 none, 1 A, 2 B, 3 parked gap), remaining gap cycles,
    // consecutive cycles B has waited during A's ownership, and B-first flag.
    int   m_own  = 0;
    int   m_gap  = 0;
    int   m_wait = 0;
    bit   m_bpri = 1'b0;

    always @(negedge wb_clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [17:0] act;
            e   = exp_q.pop_front();
            act = {gnt_a, gnt_b, preempt_o, fcen, fsclk, fdoe, fdo, di_a, di_b};
            n_tests++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL cycle %0d outputs {gnt_a,gnt_b,preempt,fcen,fsclk,fdoe,fdo,di_a,di_b}: got %b want %b",
                         e.cyc, act, e.v);
            end
        end
    end

    task automatic step();
        exp_t e;
        logic ga, gb, pre, ce, ck, oe;
        logic [3:0] dq, da, db;
        int wnow;
        sclk_a = 1'($urandom); doe_a = 1'($urandom); do_a = 4'($urandom);
        sclk_b = 1'($urandom); doe_b = 1'($urandom); do_b = 4'($urandom);
        fdi    = 4'($urandom);

        wnow = (m_own == 1 && req_b) ? m_wait + 1 : 0;
        pre  = TMO_EN && (m_own == 1) && (wnow >= TMO) && csn_a;
        ga = (m_own == 1); gb = (m_own == 2);
        ce = 1'b1; ck = 1'b0; oe = 1'b0; dq = 4'd0;
        if (ga) begin ce = csn_a; ck = sclk_a; oe = doe_a; dq = do_a; end
        if (gb) begin ce = csn_b; ck = sclk_b; oe = doe_b; dq = do_b; end
        da = ga ? fdi : 4'd0;
        db = gb ? fdi : 4'd0;
        e.v   = {ga, gb, pre, ce, ck, oe, dq, da, db};
        e.cyc = cyc;
        exp_q.push_back(e);

        if (wb_rst_i) begin
            m_own = 0; m_gap = 0; m_wait = 0; m_bpri = 1'b0;
        end else begin
            m_wait = wnow;
            if (m_own == 0) begin
                if (m_bpri && req_b)  begin m_own = 2; m_bpri = 1'b0; end
                else if (req_a)       m_own = 1;
                else if (req_b)       begin m_own = 2; m_bpri = 1'b0; end
            end else if (m_own == 1) begin
                if (pre) m_bpri = 1'b1;
                if (pre || (!req_a && csn_a)) begin m_own = 3; m_gap = GAP; end
            end else if (m_own == 2) begin
                if (!req_b && csn_b) begin m_own = 3; m_gap = GAP; end
            end else begin
                m_gap--;
                if (m_gap == 0) m_own = 0;
            end
        end
        @(posedge wb_clk_i);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        wb_rst_i = 1'b1;
        req_a = 1'b0; csn_a = 1'b1; req_b = 1'b0; csn_b = 1'b1;
        sclk_a = 1'b0; doe_a = 1'b0; do_a = 4'd0;
        sclk_b = 1'b0; doe_b = 1'b0; do_b = 4'd0; fdi = 4'd0;
        @(posedge wb_clk_i);
        #1;
        steps(2);
        wb_rst_i = 1'b0;
        steps(2);

        // A alone: grant next cycle, pads follow A, then release
        req_a = 1'b1; step();
        csn_a = 1'b0; steps(5);
        req_a = 1'b0; csn_a = 1'b1; steps(7);

        // Simultaneous requests: A first, gap, then B
        req_a = 1'b1; req_b = 1'b1; steps(4);
        req_a = 1'b0; steps(8);
        req_b = 1'b0; steps(7);

        // A drops request mid-transaction: grant held until csn high
        req_a = 1'b1; steps(2);
        csn_a = 1'b0; step();
        req_a = 1'b0; steps(10);
        csn_a = 1'b1; steps(7);

        // Reset during B ownership with csn low
        req_b = 1'b1; steps(2);
        csn_b = 1'b0; step();
        wb_rst_i = 1'b1; step();
        wb_rst_i = 1'b0; steps(2);
        req_b = 1'b0; csn_b = 1'b1; steps(8);

        // B starves behind A (preempted only when the timeout is built)
        req_a = 1'b1; csn_a = 1'b1; req_b = 1'b1; steps(40);
        req_a = 1'b0; req_b = 1'b0; steps(10);

        // Random traffic with sticky requests and occasional reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) req_a = ~req_a;
            if ($urandom_range(0, 9) == 0) req_b = ~req_b;
            if ($urandom_range(0, 3) == 0) csn_a = ~csn_a;
            if ($urandom_range(0, 3) == 0) csn_b = ~csn_b;
            wb_rst_i = ($urandom_range(0, 199) == 0);
            step();
        end
        wb_rst_i = 1'b0;

        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
